dm_subword_access: RTL
======================

# dm_subword_access

Sequential memory-access unit between the datapath and the word-wide data memory. It performs byte, halfword and word loads and stores, extending loaded sub-words to 32 bits (sign or zero). It narrows and merges stored sub-words into the addressed word by read-modify-write. It replaces direct DM wiring in the multi-cycle datapath and handles a synchronous-read RAM with 1-cycle read latency.

## Interface
- ADDR_W, 10, word-address width of the data memory (1024 words)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_sext  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte/half taken from bits [7:0]/[15:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualifies resp_valid: misaligned or illegal size
- resp_rdata  out  32  load result; 0 for stores and errors
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (with mem_en)
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we=0

## Operation
- States: IDLE, RD, MRG, WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we, size, sext, addr, wdata.
  - Error if size=11, half with addr[0]=1, or word with addr[1:0]!=0. Error goes to RESP with resp_err=1, no memory access.
  - Word store goes to WR.
  - All other requests go to RD.
- RD: mem_en=1, mem_we=0, then MRG.
- MRG: mem_rdata valid.
  - Load: select lane, extend, register into resp_rdata, then RESP.
  - Sub-word store: build merged word, then WR.
- WR: mem_en=1, mem_we=1, mem_wdata = merged word (or req_wdata for a word store), then RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No backpressure.
- Lanes are little-endian.
  - Byte at offset k occupies bits [8k+7:8k].
  - Half at offset 0 is [15:0]; at offset 2 it is [31:16].
  - Other lanes of a merged word keep their read values.
- Load extension: byte sext fills [31:8] with bit 7; half sext fills [31:16] with bit 15; zext fills with 0. Word loads are returned unchanged.
- Only ADDR_W word-address bits are used. Upper address bits are ignored and wrap silently.

## Timing
- Accept edge = cycle 0.
- Latencies from accept to resp_valid:
  - Word store: 2 cycles (WR in cycle 1).
  - Load: 3 cycles.
  - Sub-word store: 4 cycles.
  - Error: 1 cycle.
- Back-to-back: a new request is accepted in the cycle after RESP, so there are no overlapping accesses.
- Reset values: req_ready=1; resp_valid, resp_err, mem_en, mem_we = 0; resp_rdata, mem_wdata, mem_addr = 0; state IDLE.
- Reset asserted mid-operation: memory strobes drop immediately. A pending write is abandoned and memory is not partially written. No response is produced.
- mem_en, mem_we, mem_addr and mem_wdata are registered outputs. They are driven during the state they belong to.

## Configuration
- Macro DM_MERGE_CACHE_EN.
- Defined: a one-entry cache (valid bit, word address, word data) holds the last word written in WR.
  - A sub-word store whose word address matches a valid entry skips RD/MRG and merges into the cached word: IDLE, WR, RESP, latency 2.
  - Every WR updates the entry.
  - reset clears the valid bit.
  - Loads always read memory.
- Undefined: no cache. Sub-word stores always take the read-modify-write path.

## Test plan
- Word store: addr 0x10, data 0xDEADBEEF, then word load from 0x10. Expect the store response 2 cycles after accept with mem_addr=4 and mem_wdata=0xDEADBEEF. Expect the load to return 0xDEADBEEF 3 cycles after accept.
- Sub-word merge: store byte 0x5A at 0x11, then half 0x1234 at 0x12. Expect memory 0x12345AEF. Without the macro the sub-word store response comes 4 cycles after accept; with DM_MERGE_CACHE_EN it comes 2 cycles after accept.
- Extension: memory word 0x80F17F00.
  - lb sext at offset 3 gives 0xFFFFFF80.
  - lbu at offset 3 gives 0x00000080.
  - lh sext at offset 2 gives 0xFFFF80F1.
  - lhu at offset 0 gives 0x00007F00.
- Errors: half at 0x3, word at 0x6, size=11. Each gives resp_err=1 one cycle after accept, mem_en never asserts, and memory is unchanged.
- Reset in WR of a sub-word store: mem_we drops asynchronously and the memory word is unchanged. Expect req_ready=1 and resp_valid=0 after reset. With the macro, the following sub-word store takes the 4-cycle path.

Source files
------------

// File: rtl/dm_subword_access.sv
// Byte/half/word load-store unit in front of a sync-read word RAM.
// Optional DM_MERGE_CACHE_EN: one-entry cache of the last written word.
module dm_subword_access #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, MRG, WR, RESP
  } state_t;

  state_t      state;
  logic        we;
  logic        sext;
  logic [1:0]  size;
  logic [1:0]  off;
  logic [31:0] wdata;

  logic              reqErr;
  logic              reqWordSt;
  logic [ADDR_W-1:0] reqWord;
  logic              unusedBits;

`ifdef DM_MERGE_CACHE_EN
  logic              cacheValid;
  logic [ADDR_W-1:0] cacheAddr;
  logic [31:0]       cacheData;
  logic              cacheHit;
`endif

  assign req_ready  = (state == IDLE);
  assign reqWord    = req_addr[ADDR_W+1:2];
  assign unusedBits = ^req_addr[31:ADDR_W+2];
  assign reqWordSt  = req_we && (req_size == 2'b10);

  assign reqErr = (req_size == 2'b11)
               || ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (|req_addr[1:0]));

`ifdef DM_MERGE_CACHE_EN
  assign cacheHit = req_we && cacheValid
                 && (cacheAddr == reqWord);
`endif

  // half selects its lane from offset bit 1; byte from both bits
  function automatic logic [31:0] mergeWord(
    input logic [31:0] base,
    input logic [1:0]  o,
    input logic        isHalf,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = base;
    if (!isHalf)
      r[{o, 3'b000} +: 8] = d[7:0];
    else if (o[1])
      r[31:16] = d[15:0];
    else
      r[15:0] = d[15:0];
    return r;
  endfunction

  function automatic logic [31:0] loadExt(
    input logic [31:0] w,
    input logic [1:0]  o,
    input logic [1:0]  sz,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{o, 3'b000} +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      (sz == 2'b00): r = {{24{sx & b[7]}}, b};
      (sz == 2'b01): r = {{16{sx & h[15]}}, h};
      default:       r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we         <= 1'b0;
      sext       <= 1'b0;
      size       <= 2'b00;
      off        <= 2'b00;
      wdata      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef DM_MERGE_CACHE_EN
      cacheValid <= 1'b0;
      cacheAddr  <= '0;
      cacheData  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we         <= req_we;
            sext       <= req_sext;
            size       <= req_size;
            off        <= req_addr[1:0];
            wdata      <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (reqErr) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (reqWordSt) begin
              mem_addr  <= reqWord;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WR;
`ifdef DM_MERGE_CACHE_EN
            end else if (cacheHit) begin
              mem_addr  <= reqWord;
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= mergeWord(cacheData,
                req_addr[1:0], req_size[0],
                req_wdata);
              state     <= WR;
`endif
            end else begin
              mem_addr <= reqWord;
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              state    <= RD;
            end
          end
        end
        RD: begin
          mem_en <= 1'b0;
          state  <= MRG;
        end
        MRG: begin
          if (we) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= mergeWord(mem_rdata, off,
              size[0], wdata);
            state     <= WR;
          end else begin
            resp_rdata <= loadExt(mem_rdata, off,
              size, sext);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WR: begin
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
`ifdef DM_MERGE_CACHE_EN
          cacheValid <= 1'b1;
          cacheAddr  <= mem_addr;
          cacheData  <= mem_wdata;
`endif
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
